// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries operands, decoded controls and immediates
// into EXE, with flush-to-bubble, freeze-hold and WB snooping of held operands.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        status_in,
    input  logic              wb_en_wb,
    input  logic [REG_AW-1:0] dest_wb,
    input  logic [DATA_W-1:0] result_wb,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [3:0]        exe_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        status_out
);

    logic refresh_rn;
    logic refresh_rm;

    // A held operand must track write-backs, otherwise EXE would consume a stale value after the stall.
    assign refresh_rn = valid_out && wb_en_wb && (dest_wb == src1_out);
    assign refresh_rm = valid_out && wb_en_wb && (dest_wb == src2_out);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_out         <= 1'b0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            dest_out          <= '0;
            exe_cmd_out       <= '0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            status_out        <= '0;
        end else if (freeze) begin
            if (refresh_rn) val_rn_out <= result_wb;
            if (refresh_rm) val_rm_out <= result_wb;
        end else begin
            valid_out         <= 1'b1;
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            dest_out          <= dest_in;
            exe_cmd_out       <= exe_cmd_in;
            mem_r_en_out      <= mem_r_en_in;
            mem_w_en_out      <= mem_w_en_in;
            wb_en_out         <= wb_en_in;
            b_out             <= b_in;
            s_out             <= s_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            status_out        <= status_in;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: a reference model pushes the expected
// register contents per edge into a scoreboard queue that each test pops and checks.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic        mem_r;
        logic        mem_w;
        logic        wb;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  status;
    } in_t;

    typedef struct packed {
        logic valid;
        in_t  f;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, flush, freeze, wb_en_wb;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
    in_t         cur_in;
    out_t        obs, model, exp, held;
    out_t        sb_q[$];
    int          vectors = 0;
    int          errors = 0;

    logic        valid_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  src1_out, src2_out, dest_out, exe_cmd_out, status_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .pc_in(cur_in.pc), .val_rn_in(cur_in.rn), .val_rm_in(cur_in.rm),
        .src1_in(cur_in.src1), .src2_in(cur_in.src2), .dest_in(cur_in.dest),
        .exe_cmd_in(cur_in.exe_cmd), .mem_r_en_in(cur_in.mem_r), .mem_w_en_in(cur_in.mem_w),
        .wb_en_in(cur_in.wb), .b_in(cur_in.b), .s_in(cur_in.s), .imm_in(cur_in.imm),
        .shift_operand_in(cur_in.shift), .signed_imm_24_in(cur_in.simm), .status_in(cur_in.status),
        .wb_en_wb(wb_en_wb), .dest_wb(dest_wb), .result_wb(result_wb),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .src1_out(src1_out), .src2_out(src2_out), .dest_out(dest_out), .exe_cmd_out(exe_cmd_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
        .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .status_out(status_out)
    );

    assign obs = {valid_out, pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out,
                  exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
                  shift_operand_out, signed_imm_24_out, status_out};

    function automatic out_t model_next(out_t cur, in_t i, logic r, logic fl, logic fz,
                                        logic we, logic [3:0] dw, logic [31:0] res);
        out_t n;
        n = cur;
        if (r || fl) begin
            n = '0;
        end else if (fz) begin
            if (cur.valid && we && dw == cur.f.src1) n.f.rn = res;
            if (cur.valid && we && dw == cur.f.src2) n.f.rm = res;
        end else begin
            n.valid = 1'b1;
            n.f = i;
        end
        return n;
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    // Advance one edge, queueing the model's prediction; outputs are sampled 1 time unit later.
    task automatic tick();
        exp = model_next(model, cur_in, rst, flush, freeze, wb_en_wb, dest_wb, result_wb);
        model = exp;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; freeze = 1'b1; wb_en_wb = 1'b1;
        dest_wb = 4'hF; result_wb = 32'hFFFF_FFFF;
        cur_in = '1;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL reset_%0d got %h exp %h", k, obs, exp);
            end
        end
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_all_zero got %h exp 0", obs);
        end
        rst = 1'b0; flush = 1'b0; freeze = 1'b0; wb_en_wb = 1'b0;
        dest_wb = '0; result_wb = '0;
        cur_in = '0;
        cur_in.pc = 32'h10; cur_in.rn = 32'h5; cur_in.wb = 1'b1;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL first_load got %h exp %h", obs, exp);
        end
        vectors++;
        if ({pc_out, val_rn_out, wb_en_out, valid_out} !== {32'h10, 32'h5, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL first_load_fields got pc=%h rn=%h wb=%b v=%b exp pc=10 rn=5 wb=1 v=1",
                     pc_out, val_rn_out, wb_en_out, valid_out);
        end
    endtask

    task automatic test_freeze();
        in_t b_instr;
        cur_in = rand_in();
        cur_in.dest = 4'd3; cur_in.exe_cmd = 4'h2;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL freeze_load_a got %h exp %h", obs, exp);
        end
        held = exp;
        freeze = 1'b1;
        b_instr = rand_in();
        b_instr.dest = 4'd9;
        cur_in = b_instr;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = sb_q.pop_front();
            vectors++;
            if (obs !== exp || obs !== held) begin
                errors++;
                $display("[TB] FAIL freeze_hold_%0d got %h exp %h", k, obs, held);
            end
        end
        freeze = 1'b0;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || obs.f !== b_instr || valid_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL freeze_release got %h exp %h", obs, {1'b1, b_instr});
        end
    endtask

    task automatic test_refresh();
        cur_in = rand_in();
        cur_in.src1 = 4'd4; cur_in.src2 = 4'd4; cur_in.rn = 32'h11; cur_in.rm = 32'h22;
        tick();
        void'(sb_q.pop_front());
        held = model;
        freeze = 1'b1; wb_en_wb = 1'b1; dest_wb = 4'd4; result_wb = 32'hABCD;
        cur_in = rand_in();
        tick();
        exp = sb_q.pop_front();
        held.f.rn = 32'hABCD; held.f.rm = 32'hABCD;
        vectors++;
        if (obs !== exp || obs !== held) begin
            errors++;
            $display("[TB] FAIL refresh_both got %h exp %h", obs, held);
        end
        dest_wb = 4'd5; result_wb = 32'h1234;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || obs !== held) begin
            errors++;
            $display("[TB] FAIL refresh_miss got %h exp %h", obs, held);
        end
        // distinct indices: only the Rm operand should pick up the write-back
        freeze = 1'b0; wb_en_wb = 1'b0;
        cur_in = rand_in();
        cur_in.src1 = 4'd6; cur_in.src2 = 4'd7;
        tick();
        void'(sb_q.pop_front());
        held = model;
        freeze = 1'b1; wb_en_wb = 1'b1; dest_wb = 4'd7; result_wb = 32'hCAFE_0007;
        tick();
        exp = sb_q.pop_front();
        held.f.rm = 32'hCAFE_0007;
        vectors++;
        if (obs !== exp || obs !== held) begin
            errors++;
            $display("[TB] FAIL refresh_rm_only got %h exp %h", obs, held);
        end
        freeze = 1'b0; wb_en_wb = 1'b0;
    endtask

    task automatic test_flush();
        cur_in = rand_in();
        cur_in.mem_w = 1'b1; cur_in.wb = 1'b0; cur_in.src1 = 4'd0;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || mem_w_en_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_store_load got %h exp %h", obs, exp);
        end
        flush = 1'b1; freeze = 1'b1;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || obs !== '0) begin
            errors++;
            $display("[TB] FAIL flush_with_freeze got %h exp 0", obs);
        end
        flush = 1'b0; wb_en_wb = 1'b1; dest_wb = 4'd0; result_wb = 32'h55;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || val_rn_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL no_refresh_invalid got rn=%h exp rn=0", val_rn_out);
        end
        // a load with a matching write-back takes the ID-stage value, not result_wb
        freeze = 1'b0;
        cur_in = rand_in();
        cur_in.src1 = 4'd0; cur_in.rn = 32'h0BAD_F00D;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || val_rn_out !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL no_refresh_on_load got rn=%h exp rn=0badf00d", val_rn_out);
        end
        wb_en_wb = 1'b0;
    endtask

    task automatic test_reset_mid_freeze();
        cur_in = rand_in();
        cur_in.src1 = 4'd2;
        tick();
        void'(sb_q.pop_front());
        freeze = 1'b1; wb_en_wb = 1'b1; dest_wb = 4'd2; result_wb = 32'h7777;
        rst = 1'b1;
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_freeze got %h exp 0", obs);
        end
        rst = 1'b0; freeze = 1'b0; wb_en_wb = 1'b0;
        cur_in = rand_in();
        tick();
        exp = sb_q.pop_front();
        vectors++;
        if (obs !== exp || obs !== {1'b1, cur_in}) begin
            errors++;
            $display("[TB] FAIL load_after_reset got %h exp %h", obs, {1'b1, cur_in});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            cur_in = rand_in();
            flush = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 2) == 0);
            wb_en_wb = $urandom_range(0, 1);
            dest_wb = $urandom_range(0, 1) ? model.f.src1 : 4'($urandom_range(0, 15));
            result_wb = $urandom;
            tick();
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL b2b_queue_empty got 0 entries exp 1");
            end else begin
                exp = sb_q.pop_front();
                vectors++;
                if (obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b_%0d got %h exp %h", k, obs, exp);
                end
            end
        end
        flush = 1'b0; freeze = 1'b0; wb_en_wb = 1'b0;
    endtask

    initial begin
        model = '0;
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; wb_en_wb = 1'b0;
        dest_wb = '0; result_wb = '0; cur_in = '0;
        #2;
        test_reset();
        test_freeze();
        test_refresh();
        test_flush();
        test_reset_mid_freeze();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the ARM-subset core. It sits directly downstream of the register file and decode logic.
- Latches the operands Val_Rn/Val_Rm, the decoded control word and the immediates on each rising edge, then presents them to the EXE stage.
- Supports branch flush (bubble insertion) and freeze (hold during memory stall).
- While frozen, it snoops the WB write port so a held operand never goes stale when its source register is written back.

Parameters:
- DATA_W, 32, width of PC, operands and write-back result
- REG_AW, 4, register index width (16 registers)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  branch taken in EXE; insert bubble
- freeze  input  1  hold contents (memory stall)
- pc_in  input  DATA_W  PC+4 of instruction in ID
- val_rn_in  input  DATA_W  register file Val_Rn
- val_rm_in  input  DATA_W  register file Val_Rm
- src1_in  input  REG_AW  Rn index
- src2_in  input  REG_AW  Rm/Rd index used for val_rm
- dest_in  input  REG_AW  destination register
- exe_cmd_in  input  4  ALU command
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in  input  1 each  decoded controls
- shift_operand_in  input  12  shifter operand
- signed_imm_24_in  input  24  branch offset
- status_in  input  4  NZCV flags for ALU carry-in
- wb_en_wb  input  1  WB stage write enable (same signal driving register file writeBackEn)
- dest_wb  input  REG_AW  WB destination index
- result_wb  input  DATA_W  WB result
- valid_out  output  1  slot holds a real instruction
- every *_in above (except flush/freeze/WB snoop) has a registered *_out counterpart of equal width

Behaviour:
- All state updates on the rising edge of clk. Outputs come straight from flops (no combinational path in to out). Latency is 1 cycle.
- Priority per edge: rst > flush > freeze > load.
- rst: every output is 0, including valid_out, all controls, operands, indices, PC and status.
- flush (even with freeze=1):
  - valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out and s_out all 0.
  - All data/index fields are cleared to 0, giving a clean bubble.
- freeze=1, flush=0: every field holds, except the operand refresh below.
- load (flush=0, freeze=0): every *_out takes its *_in. valid_out is 1.
- Operand refresh: applies only while frozen and valid_out=1.
  - If wb_en_wb=1 and dest_wb==src1_out, then val_rn_out takes result_wb.
  - If wb_en_wb=1 and dest_wb==src2_out, then val_rm_out takes result_wb.
  - Both operands update in the same edge if both indices match.
  - No refresh when valid_out=0 or when loading. The register file writes on the falling edge, so the ID-stage read already returns the new value.
- Deasserting freeze resumes loading on the next edge. No cycle is lost and none is duplicated.
- Width rules: pure transport, no arithmetic, no sign extension (done in EXE).

Test Plan:
- rst=1 for 2 cycles with all inputs 0xFFFF_FFFF/1 -> all outputs 0, valid_out=0. Release, apply pc_in=0x10, val_rn_in=0x5, wb_en_in=1 -> next edge pc_out=0x10, val_rn_out=0x5, wb_en_out=1, valid_out=1.
- Load instr A (dest=3, exe_cmd=0x2), then freeze=1 for 3 cycles while inputs change to B -> outputs stay A for all 3 cycles. Drop freeze -> B appears one edge later.
- Frozen with src1_out=4, src2_out=4, val_rn_out=0x11; pulse wb_en_wb=1, dest_wb=4, result_wb=0xABCD -> val_rn_out=val_rm_out=0xABCD next edge, all other fields unchanged. Repeat with dest_wb=5 -> no change.
- Frozen with valid_out=0 (after flush), wb_en_wb=1, dest_wb=0 matching src1_out=0 -> val_rn_out stays 0.
- flush=1 together with freeze=1 while holding a store (mem_w_en_out=1) -> next edge mem_w_en_out=0, wb_en_out=0, valid_out=0, all data 0.
- Assert rst mid-freeze with a refresh hit pending -> all outputs 0 next edge; first load after reset behaves normally.
